// File: rtl/aes_pkg.sv
// Shared types and constants for the AES word-stream framer.
//   state_t       : framer FSM states
//   WORD_W        : stream word width
//   WORDS_PER_BLK : words per 128-bit key / data block
package aes_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned WORDS_PER_BLK = 4;
  localparam int unsigned BLK_W         = WORD_W * WORDS_PER_BLK;
  localparam int unsigned CNT_W         = $clog2(WORDS_PER_BLK);

  // Index of the final word in a block
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_BLK - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    DRAIN   = 2'd3
  } state_t;

endpackage

// File: rtl/aes_word_packer.sv
// 4x32 shift register with word counter. Words shift in at the LSB end, so the
// first word of a group ends up in the MSB word; the MSB word is also the next
// word to leave when the register is used for unpacking.
//   clk, rst     : clock, async active-high reset
//   i_load       : parallel load of i_load_data, word count cleared
//   i_shift      : shift left one word, i_word enters at the bottom, count++
//   o_data       : full 128-bit register
//   o_cnt        : words shifted since last load/wrap (wraps at 4)
module aes_word_packer
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [BLK_W-1:0]  i_load_data,
  input  logic              i_shift,
  input  logic [WORD_W-1:0] i_word,
  output logic [BLK_W-1:0]  o_data,
  output logic [CNT_W-1:0]  o_cnt
);

  logic [BLK_W-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;

  // Load has priority over shift; counter wraps naturally at WORDS_PER_BLK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_data <= {r_data[BLK_W-WORD_W-1:0], i_word};
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  assign o_data = r_data;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/aes_stream_framer.sv
// Word-stream front/back end for the AES-128 core: packs key and plaintext
// words, pulses the core start, waits for done, then streams the ciphertext
// out as four words.
// Optional feature: define AES_FRAMER_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles (err_timeout set, block dropped).
//   clk, rst                    : clock, async active-high reset
//   s_valid/s_ready/s_data/s_key: input word stream (s_key selects key group)
//   m_valid/m_ready/m_data/m_last: ciphertext word stream
//   aes_start/aes_data_in/aes_key/aes_data_out/aes_done: core handshake
//   key_valid                   : full key loaded
//   err_nokey, err_timeout      : sticky error flags
module aes_stream_framer
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TO_W           = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_key,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  output logic              aes_start,
  output logic [BLK_W-1:0]  aes_data_in,
  output logic [BLK_W-1:0]  aes_key,
  input  logic [BLK_W-1:0]  aes_data_out,
  input  logic              aes_done,
  output logic              key_valid,
  output logic              err_nokey,
  output logic              err_timeout
);

  // Timeout counter must be able to reach TIMEOUT_CYCLES
  if (TIMEOUT_CYCLES >= (64'd1 << TO_W)) begin : g_to_w_check
    $error("TO_W too narrow for TIMEOUT_CYCLES");
  end

  state_t           r_state;
  state_t           w_next;
  logic             r_s_ready;
  logic             r_m_valid;
  logic             r_m_last;
  logic             r_aes_start;
  logic             r_key_valid;
  logic             r_err_nokey;

  logic             w_accept;
  logic             w_key_shift;
  logic             w_data_shift;
  logic             w_out_load;
  logic             w_out_shift;
  logic             w_key_valid_nxt;
  logic             w_err_nokey_nxt;
  logic             w_to_expired;
  logic [CNT_W-1:0] w_out_idx_nxt;

  logic [BLK_W-1:0] w_key_data;
  logic [BLK_W-1:0] w_pt_data;
  logic [BLK_W-1:0] w_ct_data;
  logic [CNT_W-1:0] w_key_cnt;
  logic [CNT_W-1:0] w_pt_cnt;
  logic [CNT_W-1:0] w_ct_cnt;

  aes_word_packer u_key_packer (
    .clk         (clk),
    .rst         (rst),
    .i_load      (1'b0),
    .i_load_data ({BLK_W{1'b0}}),
    .i_shift     (w_key_shift),
    .i_word      (s_data),
    .o_data      (w_key_data),
    .o_cnt       (w_key_cnt)
  );

  aes_word_packer u_pt_packer (
    .clk         (clk),
    .rst         (rst),
    .i_load      (1'b0),
    .i_load_data ({BLK_W{1'b0}}),
    .i_shift     (w_data_shift),
    .i_word      (s_data),
    .o_data      (w_pt_data),
    .o_cnt       (w_pt_cnt)
  );

  aes_word_packer u_ct_unpacker (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_out_load),
    .i_load_data (aes_data_out),
    .i_shift     (w_out_shift),
    .i_word      ({WORD_W{1'b0}}),
    .o_data      (w_ct_data),
    .o_cnt       (w_ct_cnt)
  );

`ifdef AES_FRAMER_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err_timeout;

  // Counts cycles spent in WAIT; cleared whenever the FSM is elsewhere
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_to_expired = (r_state == WAIT) && !aes_done &&
                        (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_timeout <= 1'b0;
    end else if (w_to_expired) begin
      r_err_timeout <= 1'b1;
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_to_expired = 1'b0;
  assign err_timeout  = 1'b0;
`endif

  // s_ready is registered, so it also gates the handshake right after reset
  assign w_accept = (r_state == COLLECT) && r_s_ready && s_valid;

  // Next-state and datapath control
  always_comb begin
    w_next          = r_state;
    w_key_shift     = 1'b0;
    w_data_shift    = 1'b0;
    w_out_load      = 1'b0;
    w_out_shift     = 1'b0;
    w_key_valid_nxt = r_key_valid;
    w_err_nokey_nxt = r_err_nokey;
    w_out_idx_nxt   = w_ct_cnt;

    case (r_state)
      COLLECT: begin
        if (w_accept) begin
          if (s_key) begin
            w_key_shift = 1'b1;
            // A new key invalidates the old one from its first word
            if (w_key_cnt == LAST_IDX) begin
              w_key_valid_nxt = 1'b1;
            end else if (w_key_cnt == '0) begin
              w_key_valid_nxt = 1'b0;
            end
          end else if (r_key_valid) begin
            w_data_shift = 1'b1;
            if (w_pt_cnt == LAST_IDX) begin
              w_next = START;
            end
          end else begin
            w_err_nokey_nxt = 1'b1;
          end
        end
      end
      START: begin
        w_next = WAIT;
      end
      WAIT: begin
        if (aes_done) begin
          w_out_load    = 1'b1;
          w_out_idx_nxt = '0;
          w_next        = DRAIN;
        end else if (w_to_expired) begin
          w_next = COLLECT;
        end
      end
      DRAIN: begin
        if (r_m_valid && m_ready) begin
          w_out_shift   = 1'b1;
          w_out_idx_nxt = w_ct_cnt + CNT_W'(1);
          if (w_ct_cnt == LAST_IDX) begin
            w_next = COLLECT;
          end
        end
      end
      default: begin
        w_next = COLLECT;
      end
    endcase
  end

  // State register plus outputs registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= COLLECT;
      r_s_ready   <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_aes_start <= 1'b0;
      r_key_valid <= 1'b0;
      r_err_nokey <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_s_ready   <= (w_next == COLLECT);
      r_m_valid   <= (w_next == DRAIN);
      r_m_last    <= (w_next == DRAIN) && (w_out_idx_nxt == LAST_IDX);
      r_aes_start <= (w_next == START);
      r_key_valid <= w_key_valid_nxt;
      r_err_nokey <= w_err_nokey_nxt;
    end
  end

  assign s_ready     = r_s_ready;
  assign m_valid     = r_m_valid;
  assign m_last      = r_m_last;
  assign aes_start   = r_aes_start;
  assign key_valid   = r_key_valid;
  assign err_nokey   = r_err_nokey;
  assign m_data      = w_ct_data[BLK_W-1 -: WORD_W];
  assign aes_key     = w_key_data;
  assign aes_data_in = w_pt_data;

endmodule
